// File: rtl/uart_pkg.sv
// Shared types for the UART receiver (and a future transmitter).
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE,
        ST_BREAK_WAIT
    } rx_state_t;

    // Wide enough to count up to 9 data bits or 2 stop bits.
    localparam int BIT_IDX_W = 4;

endpackage

// File: rtl/uart_rx_param_if.sv
// Link between a UART bit-timing counter and the FSM that steers it.
interface uart_rx_param_if;
    logic clr;
    logic half_tick;
    logic full_tick;

    modport master (output clr, input half_tick, input full_tick);
    modport slave  (input clr, output half_tick, output full_tick);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: clear input, half-bit and full-bit ticks.
// Wraps to zero on every full tick so sample points never drift.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    uart_rx_param_if.slave   tmr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tmr.half_tick = (cnt_q == HALF_CNT);
    assign tmr.full_tick = (cnt_q == FULL_CNT);
    assign cnt_d = (tmr.clr || tmr.full_tick) ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with parity, stop-bit, break and overrun
// detection; delivers one word per frame to a buffer with a full flag.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int      CLKS_PER_BIT = 217,
    parameter int      DATA_BITS    = 8,
    parameter parity_t PARITY       = PAR_NONE,
    parameter int      STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_rst,
    input  logic                 i_RX_Serial,
    input  logic                 i_full,
    output logic                 o_CTS,
    output logic                 o_RX_Done,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Overrun
);
    uart_rx_param_if tmr_if ();

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk_i  (i_Clock),
        .rst_ni (i_rst),
        .tmr    (tmr_if)
    );

    rx_state_t              state_q;
    logic [1:0]             sync_q;
    logic [1:0]             sync_vld_q;
    logic                   armed_q;
    logic [BIT_IDX_W-1:0]   bit_idx_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   par_bit_q;
    logic                   par_err_q;
    logic                   stop_err_q;
    logic                   stop_low_q;
    logic [DATA_BITS-1:0]   rx_byte_q;
    logic                   done_q;
    logic                   perr_out_q;
    logic                   ferr_out_q;
    logic                   brk_out_q;
    logic                   ovr_out_q;
    logic                   cts_q;
    logic                   rx_s;
    logic                   is_break;

    assign rx_s     = sync_q[1];
    assign is_break = (shreg_q == '0) && !par_bit_q && stop_low_q;

    // Counter idles at zero and restarts at the start-bit midpoint, so data
    // samples fall one full bit later, mid-bit.
    assign tmr_if.clr = (state_q == ST_IDLE) ||
                        ((state_q == ST_START) && tmr_if.half_tick);

    always_ff @(posedge i_Clock or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            sync_q     <= 2'b11;
            sync_vld_q <= 2'b00;
            armed_q    <= 1'b0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            stop_low_q <= 1'b0;
            rx_byte_q  <= '0;
            done_q     <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_out_q  <= 1'b0;
            ovr_out_q  <= 1'b0;
            cts_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], i_RX_Serial};
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            cts_q      <= ~i_full;
            done_q     <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_out_q  <= 1'b0;
            ovr_out_q  <= 1'b0;
            // Only trust the line once the reset value has left the
            // synchroniser; a line already low after reset is not a start edge.
            if (sync_vld_q[1] && rx_s) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (armed_q && !rx_s) begin
                        state_q    <= ST_START;
                        bit_idx_q  <= '0;
                        par_bit_q  <= 1'b0;
                        par_err_q  <= 1'b0;
                        stop_err_q <= 1'b0;
                        stop_low_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tmr_if.half_tick) begin
                        state_q <= rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tmr_if.full_tick) begin
                        shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                            bit_idx_q <= '0;
                            state_q   <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tmr_if.full_tick) begin
                        par_bit_q <= rx_s;
                        par_err_q <= (PARITY == PAR_ODD) ? ~((^shreg_q) ^ rx_s)
                                                         :  ((^shreg_q) ^ rx_s);
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tmr_if.full_tick) begin
                        if (rx_s) begin
                            stop_low_q <= 1'b0;
                        end else begin
                            stop_err_q <= 1'b1;
                        end
                        if (bit_idx_q == BIT_IDX_W'(STOP_BITS - 1)) begin
                            bit_idx_q <= '0;
                            state_q   <= ST_DONE;
                        end else begin
                            bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    perr_out_q <= par_err_q;
                    ferr_out_q <= stop_err_q;
                    if (is_break) begin
                        brk_out_q <= 1'b1;
                        state_q   <= ST_BREAK_WAIT;
                    end else begin
                        if (i_full) begin
                            ovr_out_q <= 1'b1;
                        end else begin
                            done_q    <= 1'b1;
                            rx_byte_q <= shreg_q;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                ST_BREAK_WAIT: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_CTS        = cts_q;
    assign o_RX_Done    = done_q;
    assign o_RX_Byte    = rx_byte_q;
    assign o_Parity_Err = perr_out_q;
    assign o_Frame_Err  = ferr_out_q;
    assign o_Break      = brk_out_q;
    assign o_Overrun    = ovr_out_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 and an 8E1 receiver on separate
// lines, a table of frames, then glitch/break/reset sequences and a timer check.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int CPB = 217;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic full = 1'b0;
    logic rx_n = 1'b1;
    logic rx_e = 1'b1;

    always #20 clk = ~clk;

    logic       n_cts, n_done, n_perr, n_ferr, n_brk, n_ovr;
    logic [7:0] n_byte;
    logic       e_cts, e_done, e_perr, e_ferr, e_brk, e_ovr;
    logic [7:0] e_byte;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_n (
        .i_Clock(clk), .i_rst(rst_n), .i_RX_Serial(rx_n), .i_full(full),
        .o_CTS(n_cts), .o_RX_Done(n_done), .o_RX_Byte(n_byte), .o_Parity_Err(n_perr),
        .o_Frame_Err(n_ferr), .o_Break(n_brk), .o_Overrun(n_ovr)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_e (
        .i_Clock(clk), .i_rst(rst_n), .i_RX_Serial(rx_e), .i_full(full),
        .o_CTS(e_cts), .o_RX_Done(e_done), .o_RX_Byte(e_byte), .o_Parity_Err(e_perr),
        .o_Frame_Err(e_ferr), .o_Break(e_brk), .o_Overrun(e_ovr)
    );

    // Standalone timer with a short period for tick-position checks.
    logic t_clr = 1'b1;
    uart_rx_param_if tif ();
    assign tif.clr = t_clr;
    uart_bit_timer #(.CLKS_PER_BIT(8)) u_tmr (.clk_i(clk), .rst_ni(rst_n), .tmr(tif));

    // Pulse counters, index 0 = 8N1 receiver, 1 = 8E1 receiver.
    int done_c[2];
    int perr_c[2];
    int ferr_c[2];
    int brk_c[2];
    int ovr_c[2];
    int both_c[2];

    always @(negedge clk) begin
        if (n_done) done_c[0]++;
        if (n_perr) perr_c[0]++;
        if (n_ferr) ferr_c[0]++;
        if (n_brk)  brk_c[0]++;
        if (n_ovr)  ovr_c[0]++;
        if (n_done && n_perr) both_c[0]++;
        if (e_done) done_c[1]++;
        if (e_perr) perr_c[1]++;
        if (e_ferr) ferr_c[1]++;
        if (e_brk)  brk_c[1]++;
        if (e_ovr)  ovr_c[1]++;
        if (e_done && e_perr) both_c[1]++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic line(input int sel, input logic v);
        if (sel == 1) rx_e = v;
        else          rx_n = v;
    endtask

    task automatic bit_time(input int sel, input logic v);
        line(sel, v);
        repeat (CPB) @(negedge clk);
    endtask

    // The 8E1 line (sel 1) carries a parity bit; the 8N1 line does not.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic par_bit, input logic stop_bit);
        bit_time(sel, 1'b0);
        for (int b = 0; b < 8; b++) bit_time(sel, d[b]);
        if (sel == 1) bit_time(sel, par_bit);
        bit_time(sel, stop_bit);
        line(sel, 1'b1);
        repeat (2 * CPB) @(negedge clk);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       par_bit;
        logic       stop_bit;
        logic       full;
        int         exp_done;
        logic [7:0] exp_byte;
        int         exp_perr;
        int         exp_ferr;
        int         exp_brk;
        int         exp_ovr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int b_done, b_perr, b_ferr, b_brk, b_ovr, b_both;
        int first_half, first_full, n_half, n_full;

        //            sel data   par stop full done byte   perr ferr brk ovr
        vecs[0] = '{0, 8'h3F, 0, 1, 0, 1, 8'h3F, 0, 0, 0, 0};
        vecs[1] = '{1, 8'hA5, 1, 1, 0, 1, 8'hA5, 1, 0, 0, 0};
        vecs[2] = '{1, 8'h3C, 0, 1, 0, 1, 8'h3C, 0, 0, 0, 0};
        vecs[3] = '{0, 8'h55, 0, 0, 0, 1, 8'h55, 0, 1, 0, 0};
        vecs[4] = '{0, 8'h81, 0, 1, 1, 0, 8'h55, 0, 0, 0, 1};
        vecs[5] = '{0, 8'h00, 0, 1, 0, 1, 8'h00, 0, 0, 0, 0};
        vecs[6] = '{1, 8'h01, 0, 1, 0, 1, 8'h01, 1, 0, 0, 0};
        vecs[7] = '{0, 8'hFF, 0, 1, 0, 1, 8'hFF, 0, 0, 0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_byte", 32'(n_byte), 32'h0);
        check("rst_done", 32'(n_done), 32'h0);
        check("rst_cts",  32'(n_cts),  32'h0);
        check("rst_ferr", 32'(e_ferr), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("cts_idle", 32'(n_cts), 32'h1);
        full = 1'b1;
        @(negedge clk);
        check("cts_full", 32'(n_cts), 32'h0);
        full = 1'b0;
        @(negedge clk);
        check("cts_free", 32'(n_cts), 32'h1);

        // Bit timer tick positions with an 8-clock bit
        @(negedge clk);
        t_clr = 1'b0;
        first_half = -1; first_full = -1; n_half = 0; n_full = 0;
        for (int k = 0; k < 16; k++) begin
            if (tif.half_tick) begin
                n_half++;
                if (first_half < 0) first_half = k;
            end
            if (tif.full_tick) begin
                n_full++;
                if (first_full < 0) first_full = k;
            end
            @(negedge clk);
        end
        check("tmr_half_pos", 32'(first_half), 32'd3);
        check("tmr_full_pos", 32'(first_full), 32'd7);
        check("tmr_full_cnt", 32'(n_full), 32'd2);
        check("tmr_half_cnt", 32'(n_half), 32'd2);

        // Table of frames
        for (int i = 0; i < 8; i++) begin
            int s;
            s = vecs[i].sel;
            b_done = done_c[s]; b_perr = perr_c[s]; b_ferr = ferr_c[s];
            b_brk = brk_c[s]; b_ovr = ovr_c[s]; b_both = both_c[s];
            full = vecs[i].full;
            repeat (2) @(negedge clk);
            send_frame(s, vecs[i].data, vecs[i].par_bit, vecs[i].stop_bit);
            check($sformatf("v%0d_done", i), 32'(done_c[s] - b_done), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_byte", i), 32'(s == 1 ? e_byte : n_byte), 32'(vecs[i].exp_byte));
            check($sformatf("v%0d_perr", i), 32'(perr_c[s] - b_perr), 32'(vecs[i].exp_perr));
            check($sformatf("v%0d_ferr", i), 32'(ferr_c[s] - b_ferr), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_brk", i),  32'(brk_c[s] - b_brk),   32'(vecs[i].exp_brk));
            check($sformatf("v%0d_ovr", i),  32'(ovr_c[s] - b_ovr),   32'(vecs[i].exp_ovr));
            check($sformatf("v%0d_cts", i),  32'(s == 1 ? e_cts : n_cts), 32'(!vecs[i].full));
            if (vecs[i].exp_perr != 0 && vecs[i].exp_done != 0)
                check($sformatf("v%0d_perr_with_done", i), 32'(both_c[s] - b_both), 32'd1);
            full = 1'b0;
            repeat (2) @(negedge clk);
        end

        // Short low glitch on the idle line, then a good frame
        b_done = done_c[0]; b_ferr = ferr_c[0]; b_brk = brk_c[0];
        line(0, 1'b0);
        repeat (50) @(negedge clk);
        line(0, 1'b1);
        repeat (300) @(negedge clk);
        check("glitch_done", 32'(done_c[0] - b_done), 32'd0);
        check("glitch_ferr", 32'(ferr_c[0] - b_ferr), 32'd0);
        check("glitch_brk",  32'(brk_c[0] - b_brk),   32'd0);
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        check("glitch_next_done", 32'(done_c[0] - b_done), 32'd1);
        check("glitch_next_byte", 32'(n_byte), 32'h3C);

        // Break: 15 bit times low, then idle, then a good frame
        b_done = done_c[0]; b_ferr = ferr_c[0]; b_brk = brk_c[0];
        line(0, 1'b0);
        repeat (15 * CPB) @(negedge clk);
        line(0, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("break_brk",  32'(brk_c[0] - b_brk),   32'd1);
        check("break_ferr", 32'(ferr_c[0] - b_ferr), 32'd1);
        check("break_done", 32'(done_c[0] - b_done), 32'd0);
        send_frame(0, 8'h12, 1'b0, 1'b1);
        check("break_next_done", 32'(done_c[0] - b_done), 32'd1);
        check("break_next_byte", 32'(n_byte), 32'h12);
        check("break_next_brk",  32'(brk_c[0] - b_brk), 32'd1);

        // Reset pulsed during data bit 4 of 0x0F; the line is low when it ends
        b_done = done_c[0];
        bit_time(0, 1'b0);
        for (int b = 0; b < 4; b++) bit_time(0, 1'b1);
        line(0, 1'b0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (CPB - 30) @(negedge clk);
        for (int b = 5; b < 8; b++) bit_time(0, 1'b0);
        bit_time(0, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("rstmid_done",   32'(done_c[0] - b_done), 32'd0);
        check("rstmid_byte",   32'(n_byte), 32'h00);
        check("rstmid_e_byte", 32'(e_byte), 32'h00);
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        check("rstmid_next_done", 32'(done_c[0] - b_done), 32'd1);
        check("rstmid_next_byte", 32'(n_byte), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning clocks per serial bit (minimum 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-003 SHALL have parameter PARITY, default PAR_NONE, meaning parity mode (PAR_NONE/PAR_EVEN/PAR_ODD).
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked (1 or 2).
REQ-005 SHALL have port i_Clock, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, meaning reset: asynchronous, active-low.
REQ-007 SHALL have port i_RX_Serial, input, 1, meaning the asynchronous serial line, idle high.
REQ-008 SHALL have port i_full, input, 1, meaning the downstream buffer cannot accept a word.
REQ-009 SHALL have port o_CTS, output, 1, meaning clear-to-send, registered inverse of i_full.
REQ-010 SHALL have port o_RX_Done, output, 1, meaning a one-cycle pulse when a frame is delivered.
REQ-011 SHALL have port o_RX_Byte, output, DATA_BITS, meaning the received word, LSB first on the line, held until the next delivery.
REQ-012 SHALL have ports o_Parity_Err, o_Frame_Err, o_Break, o_Overrun, output, 1 each, meaning frame status, each a one-cycle pulse coincident with end of frame.

Function
REQ-013 SHALL pass i_RX_Serial through a 2-flop synchroniser (reset value 1); all sampling uses the synchronised line.
REQ-014 SHALL use the states IDLE, START, DATA, PARITY, STOP, DONE, BREAK_WAIT.
REQ-015 IDLE: a low synchronised line SHALL move to START with the bit counter cleared.
REQ-016 START: at count (CLKS_PER_BIT-1)/2 the line SHALL be sampled; low -> DATA with counter cleared; high -> IDLE as a glitch with no output pulse.
REQ-017 DATA: the line SHALL be sampled each time the counter reaches CLKS_PER_BIT-1; samples shift LSB first; after DATA_BITS samples -> PARITY if PARITY != PAR_NONE, else STOP.
REQ-018 PARITY: one sample; error if XOR(data, sample) is 1 for PAR_EVEN or 0 for PAR_ODD.
REQ-019 STOP: STOP_BITS samples at full-bit spacing; any low sample SHALL set frame error; then -> DONE.
REQ-020 DONE, one cycle: if i_full is low, o_RX_Done=1 and o_RX_Byte is updated with the word; if i_full is high, o_Overrun=1, o_RX_Done=0 and o_RX_Byte is unchanged.
REQ-021 DONE: error pulses SHALL assert in that same cycle regardless of i_full.
REQ-022 Break is defined as all data bits 0, parity bit 0 when present, and all stop samples 0: SHALL pulse o_Break and o_Frame_Err, SHALL NOT pulse o_RX_Done, then -> BREAK_WAIT.
REQ-023 BREAK_WAIT SHALL remain until the synchronised line is high, then -> IDLE.
REQ-024 o_RX_Done SHALL assert exactly one cycle after the last stop-bit sample; the next start edge SHALL be accepted from the cycle after DONE.
REQ-025 The bit counter SHALL be $clog2(CLKS_PER_BIT) wide and wrap to 0 on each sample, with no drift accumulation.
REQ-026 i_full SHALL be sampled only in DONE; changes elsewhere SHALL affect only o_CTS, one cycle later.

Reset
REQ-027 While i_rst is low: state=IDLE, counters=0, synchroniser=1, o_RX_Byte=0, all pulse outputs=0, o_CTS=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no o_RX_Done; after release, a frame SHALL be received only after a new falling edge.

Structure
REQ-029 Package uart_pkg SHALL hold the parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD) and the rx_state_t enum.
REQ-030 Bit timing SHALL be a sub-module uart_bit_timer (counter with clear input and half/full-bit tick outputs), reusable by a future uart_tx_param.

Verification (CLKS_PER_BIT=217, 40 ns clock, bit = 8680 ns)
REQ-031 8N1, byte 0x3F, i_full=0 -> one o_RX_Done pulse, o_RX_Byte=0x3F, no error pulses.
REQ-032 PAR_EVEN, byte 0xA5 sent with parity bit 1 -> o_RX_Done with byte 0xA5 and o_Parity_Err=1 in the same cycle.
REQ-033 8N1, byte 0x55 with stop bit driven low -> o_Frame_Err=1, o_Break=0, o_RX_Byte=0x55.
REQ-034 Low glitch of 2000 ns on the idle line -> FSM returns to IDLE, no pulses; a following 0x3C frame is received correctly.
REQ-035 i_full=1 during a 0x81 frame -> o_Overrun pulse, no o_RX_Done, o_RX_Byte keeps its previous value, o_CTS=0.
REQ-036 Line held low for 15 bit times, then high, then byte 0x12 sent -> one o_Break pulse, no o_RX_Done for the break, then 0x12 delivered; separately, i_rst pulsed low at data bit 4 -> no o_RX_Done for that frame.
